mac_pipe: RTL

Parametrised, fully pipelined dot-product engine for the convolver. Each cycle it accepts one TAPS-wide window of line pixels and filter weights, scales each product by 2^-SCALE, reduces the products through a registered adder tree, and can accumulate results across several input channels before emitting one saturated result. It sits between the line buffers and the convolver output/activation stage, and accepts one window per cycle.

---
 rtl/mac_pkg.sv | 65 ++++++
 rtl/mac_adder_tree.sv | 65 ++++++
 rtl/mac_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared types, default parameters and arithmetic helpers for the
// mac_pipe dot-product engine.
//   beat_t       - valid/first/last sideband that travels with each window
//   round_shift  - floor or round-half-up arithmetic right shift
//   sat / sat_hit - two's-complement clamp to a given width, and its flag
//   tree_levels / level_nodes / level_width - adder tree geometry
package mac_pkg;

    localparam int DEF_TAPS       = 9;
    localparam int DEF_WID_LINE   = 16;
    localparam int DEF_WID_FILTER = 16;
    localparam int DEF_WID_OUT    = 32;
    localparam int DEF_SCALE      = 8;

    // Wide enough for every intermediate at the supported widths.
    typedef logic signed [63:0] calc_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_t;

    function automatic int tree_levels(input int n);
        return $clog2(n);
    endfunction

    // Operand count at a given tree level; odd operands pass through.
    function automatic int level_nodes(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic int level_width(input int w_in, input int lvl);
        return w_in + lvl;
    endfunction

    // Arithmetic shift floors toward -inf; the bias turns it into round-half-up.
    function automatic calc_t round_shift(input calc_t x, input int sh, input logic rnd);
        calc_t bias;
        bias = rnd ? (calc_t'(1) <<< (sh - 1)) : calc_t'(0);
        return (x + bias) >>> sh;
    endfunction

    function automatic calc_t sat(input calc_t x, input int w);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo = -(calc_t'(1) <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic logic sat_hit(input calc_t x, input int w);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo = -(calc_t'(1) <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// mac_adder_tree: registered binary reduction of N signed operands.
//   clk, rst   - clock, async active-high reset
//   clear      - drops all in-flight sideband (valid/first/last)
//   in_data    - N operands of W_IN bits, operand k at [k*W_IN +: W_IN]
//   in_beat    - sideband entering with in_data
//   out_sum    - sum of all operands, W_IN + clog2(N) bits, L cycles later
//   out_beat   - sideband aligned with out_sum
module mac_adder_tree
    import mac_pkg::*;
#(
    parameter int N    = DEF_TAPS,
    parameter int W_IN = 25
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic [N*W_IN-1:0]                in_data,
    input  beat_t                            in_beat,
    output logic signed [W_IN+$clog2(N)-1:0] out_sum,
    output beat_t                            out_beat
);

    localparam int L = tree_levels(N);

    // Level g holds level_nodes(N, g) operands, each one bit wider than the
    // level before, so no sum inside the tree can overflow.
    for (genvar g = 0; g <= L; g++) begin : lv
        localparam int NN = level_nodes(N, g);
        localparam int WW = level_width(W_IN, g);
        for (genvar k = 0; k < NN; k++) begin : nd
            logic signed [WW-1:0] q;
            if (g == 0) begin : leaf
                assign q = in_data[k*W_IN +: W_IN];
            end else if (2 * k + 1 < level_nodes(N, g - 1)) begin : add
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) q <= '0;
                    else     q <= WW'(lv[g-1].nd[2*k].q) + WW'(lv[g-1].nd[2*k+1].q);
                end
            end else begin : pass
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) q <= '0;
                    else     q <= WW'(lv[g-1].nd[2*k].q);
                end
            end
        end
    end

    assign out_sum = lv[L].nd[0].q;

    beat_t sb [L];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) sb[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < L; i++) sb[i] <= '0;
        end else begin
            sb[0] <= in_beat;
            for (int i = 1; i < L; i++) sb[i] <= sb[i-1];
        end
    end

    assign out_beat = sb[L-1];

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: pipelined TAPS-wide dot product with per-product scaling,
// cross-window accumulation and output saturation. Latency clog2(TAPS)+2.
//   clk, rst     - clock, async active-high reset
//   clear        - sync flush: zero accumulator, drop in-flight windows
//   in_valid     - window present; in_first / in_last / round_en qualify it
//   line_flat    - TAPS pixels, tap i at [i*WID_LINE +: WID_LINE]
//   filter_flat  - TAPS weights, same packing
//   out_valid    - one-cycle pulse with the group result
//   out_data     - saturated accumulated result
//   out_sat      - clamp engaged somewhere in the emitted group
module mac_pipe
    import mac_pkg::*;
#(
    parameter int TAPS       = DEF_TAPS,
    parameter int WID_LINE   = DEF_WID_LINE,
    parameter int WID_FILTER = DEF_WID_FILTER,
    parameter int WID_OUT    = DEF_WID_OUT,
    parameter int SCALE      = DEF_SCALE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic                         round_en,
    input  logic [TAPS*WID_LINE-1:0]     line_flat,
    input  logic [TAPS*WID_FILTER-1:0]   filter_flat,
    output logic                         out_valid,
    output logic signed [WID_OUT-1:0]    out_data,
    output logic                         out_sat
);

    localparam int WP = WID_LINE + WID_FILTER;
    // One spare bit over the shifted product covers the rounding bias.
    localparam int WS = WP - SCALE + 1;
    localparam int L  = tree_levels(TAPS);
    localparam int WT = level_width(WS, L);

    // Stage M: multiply and scale every tap.
    logic signed [WID_LINE-1:0]   pix;
    logic signed [WID_FILTER-1:0] wgt;
    logic signed [WP-1:0]         prod;
    logic [TAPS*WS-1:0]           s_flat;

    always_comb begin
        s_flat = '0;
        pix    = '0;
        wgt    = '0;
        prod   = '0;
        for (int i = 0; i < TAPS; i++) begin
            pix  = line_flat[i*WID_LINE +: WID_LINE];
            wgt  = filter_flat[i*WID_FILTER +: WID_FILTER];
            prod = WP'(pix) * WP'(wgt);
            s_flat[i*WS +: WS] = WS'(round_shift(calc_t'(prod), SCALE, round_en));
        end
    end

    logic [TAPS*WS-1:0] m_data;
    beat_t              m_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= '0;
            m_beat <= '0;
        end else begin
            m_data <= s_flat;
            if (clear) m_beat <= '0;
            else       m_beat <= '{valid: in_valid, first: in_first, last: in_last};
        end
    end

    logic signed [WT-1:0] t_sum;
    beat_t                t_beat;

    mac_adder_tree #(
        .N    (TAPS),
        .W_IN (WS)
    ) u_tree (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_data  (m_data),
        .in_beat  (m_beat),
        .out_sum  (t_sum),
        .out_beat (t_beat)
    );

    // Stage A: accumulate with clamp; first restarts both acc and the flag.
    logic signed [WID_OUT-1:0] acc;
    logic                      sat_g;
    calc_t                     acc_base;
    calc_t                     acc_raw;
    logic signed [WID_OUT-1:0] acc_nxt;
    logic                      hit;
    logic                      sat_nxt;

    always_comb begin
        acc_base = t_beat.first ? calc_t'(0) : calc_t'(acc);
        acc_raw  = acc_base + calc_t'(t_sum);
        acc_nxt  = WID_OUT'(sat(acc_raw, WID_OUT));
        hit      = sat_hit(acc_raw, WID_OUT);
        sat_nxt  = hit | (~t_beat.first & sat_g);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sat_g     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            sat_g     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= t_beat.valid & t_beat.last;
            if (t_beat.valid) begin
                acc   <= acc_nxt;
                sat_g <= sat_nxt;
                if (t_beat.last) begin
                    out_data <= acc_nxt;
                    out_sat  <= sat_nxt;
                end
            end
        end
    end

endmodule
